mux_scan_serializer: RTL and testbench
======================================

Name: mux_scan_serializer

Overview:
- Upstream select-sequencing stage for the 16:1 bit-select mux path.
- Captures a 16-bit parallel word on a start request.
- Walks a 4-bit select index through every position, presenting one selected bit per handshake on a serial output.
- Exports the live select index so an external N:1 mux can be driven in lock-step.
- Reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 16, number of parallel input bits; power of two, at least 2.
- SELW, 4, select index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request to load din and begin a scan; sampled only in IDLE.
- din  input  WIDTH  parallel word; captured on the accepted start.
- msb_first  input  1  scan order; captured with din. 0 means index 0 up to WIDTH-1; 1 means WIDTH-1 down to 0.
- ready  input  1  downstream accepts the current serial bit this cycle.
- sout  output  1  currently selected bit, shadow[sel].
- sel  output  SELW  current select index.
- valid  output  1  sout and sel hold a bit that is offered to downstream.
- busy  output  1  a scan is in progress.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (rstn=0, takes effect immediately): state=IDLE, shadow=0, order=0, sel=0, sout=0, valid=0, busy=0, done=0. A reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SHIFT, DONE. State and all outputs are registered. sout is derived from the registered shadow and sel.
- IDLE, start=1 at a clock edge:
  - shadow<=din, order<=msb_first.
  - sel<=(msb_first ? WIDTH-1 : 0); state<=SHIFT.
  - valid and busy become 1 in the next cycle, so first-bit latency is 1 cycle.
- IDLE, start=0: hold all registers.
- SHIFT, valid&&ready with sel not equal to the last index: step sel by +1 (order=0) or -1 (order=1). The next bit is presented in the following cycle.
- SHIFT, valid&&ready with sel at the last index (WIDTH-1 for order=0, 0 for order=1):
  - state<=DONE, valid<=0, busy<=0, done<=1.
  - sel holds its final value.
- SHIFT, ready=0: sel, sout and valid hold (stall). There is no timeout.
- DONE: done lasts exactly 1 cycle, then state<=IDLE and done<=0. A start asserted during the DONE cycle is ignored. A start is accepted again from the first IDLE cycle.
- start asserted in SHIFT or DONE is ignored. Changes to din or msb_first during a scan do not affect the captured word or order.
- Timing with ready held high: 16 bit-cycles. done is high in the cycle after the last handshake, so done appears 17 cycles after the start edge. Back-to-back scans have a period of 18 cycles.
- sel never wraps: index stepping stops at the last index. Order 1 decrements from WIDTH-1 and stops at 0 without underflow.
- ready while valid=0 has no effect.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE);
  - the WIDTH/SELW defaults.
- One sub-module is natural: scan_index_counter. It has a load value, an up/down control, a step enable and a last-index flag; its width is SELW.
- The bit-select is an inline indexed read of shadow; there is no separate mux module inside this block.

Test Plan:
- Reset mid-scan: start with din=16'hA5C3, msb_first=0; pulse rstn low after 5 accepted bits -> all outputs 0 immediately, state IDLE, no done pulse.
- LSB-first, ready=1: din=16'hA5C3, msb_first=0 -> sout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with sel 0..15; done high exactly at cycle 17 after the start edge, for 1 cycle.
- MSB-first: din=16'h8001, msb_first=1 -> sel 15..0; sout 1, then 0 fourteen times, then 1; sel is 0 at done; no underflow.
- Stall: ready low for 3 cycles while sel=7 -> sel=7 and sout held, valid=1 throughout; scan resumes at sel=8; done appears 3 cycles later than the unstalled case.
- Ignored starts and captured inputs: start pulsed during SHIFT and during DONE, with din changed to 16'hFFFF mid-scan -> no restart, output still follows the captured word; a start in the first IDLE cycle after done begins a new scan (18-cycle period).
- Parameter check: WIDTH=4, SELW=2, din=4'b1010, msb_first=0 -> sout 0,1,0,1; done 5 cycles after start.

Source files
------------

// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the mux select-sequencing serializer: FSM encoding and
// default geometry of the 16:1 bit-select path.
package mux_scan_serializer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SELW_DEF  = 4;

  // 2'd3 is unused and steers back to idle.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/scan_index_counter.sv
// Loadable up/down select-index counter that saturates at the scan's last index
// instead of wrapping.
module scan_index_counter
  import mux_scan_serializer_pkg::*;
#(
  parameter int SELW = SELW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  input  logic            down,
  input  logic            step,
  output logic [SELW-1:0] idx,
  output logic            last
);

  // The index range is a full power of two, so all-ones is the top position.
  assign last = down ? (idx == '0) : (idx == '1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (step && !last) begin
      idx <= down ? idx - 1'b1 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Captures a parallel word and walks a select index across it, offering one bit
// per handshake and exporting the index to drive an external N:1 mux in step.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             ready,
  output logic             sout,
  output logic [SELW-1:0]  sel,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow;
  logic             order;
  logic             load;
  logic             step;
  logic             last;
  logic [SELW-1:0]  load_val;

  assign load     = (state == ST_IDLE) && start;
  assign step     = (state == ST_SHIFT) && valid && ready;
  assign load_val = msb_first ? SELW'(WIDTH - 1) : '0;
  assign sout     = shadow[sel];

  scan_index_counter #(
    .SELW(SELW)
  ) u_idx (
    .clk     (clk),
    .rstn    (rstn),
    .load    (load),
    .load_val(load_val),
    .down    (order),
    .step    (step),
    .idx     (sel),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      shadow <= '0;
      order  <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow <= din;
            order  <= msb_first;
            valid  <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The counter holds its final index; only control drops here.
          if (step && last) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: 16-bit instance for scan order, stall,
// ignored starts and reset abort, plus a 4-bit instance for the narrow geometry.
module tb_mux_scan_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] din;
  logic        msb_first;
  logic        ready;
  logic        sout;
  logic [3:0]  sel;
  logic        valid;
  logic        busy;
  logic        done;

  logic        start4;
  logic [3:0]  din4;
  logic        msb4;
  logic        ready4;
  logic        sout4;
  logic [1:0]  sel4;
  logic        valid4;
  logic        busy4;
  logic        done4;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int start_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  mux_scan_serializer #(.WIDTH(16), .SELW(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .din(din), .msb_first(msb_first),
    .ready(ready), .sout(sout), .sel(sel), .valid(valid), .busy(busy), .done(done)
  );

  mux_scan_serializer #(.WIDTH(4), .SELW(2)) dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .din(din4), .msb_first(msb4),
    .ready(ready4), .sout(sout4), .sel(sel4), .valid(valid4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one 16-bit scan from IDLE and returns in the done cycle.
  // seq[i] is the i-th bit expected on sout; cycle 1 is the first after the start edge.
  task automatic scan16(input string tag, input logic [15:0] d, input logic m,
                        input logic [15:0] seq, input int stall_sel, input int stall_n,
                        input int exp_done, input bit inject);
    int cyc;
    din = d; msb_first = m; start = 1'b1; ready = 1'b1;
    tick;
    start_edge = edge_cnt;
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 16; i++) begin
      int es;
      es = m ? 15 - i : i;
      chk({tag, "_valid"}, 32'(valid), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_sel"}, 32'(sel), es);
      chk({tag, "_sout"}, 32'(sout), 32'(seq[i]));
      if (es == stall_sel) begin
        ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick; cyc++;
          chk({tag, "_stall_sel"}, 32'(sel), es);
          chk({tag, "_stall_sout"}, 32'(sout), 32'(seq[i]));
          chk({tag, "_stall_valid"}, 32'(valid), 1);
        end
        ready = 1'b1;
      end
      if (inject && i == 8) begin
        din = 16'hFFFF; msb_first = ~m; start = 1'b1;
      end
      tick; cyc++;
      start = 1'b0;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_done_valid"}, 32'(valid), 0);
    chk({tag, "_final_sel"}, 32'(sel), m ? 0 : 15);
    chk({tag, "_done_cycle"}, cyc, exp_done);
  endtask

  task automatic after_done(input string tag);
    tick;
    chk({tag, "_done_pulse_end"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_valid"}, 32'(valid), 0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; din = '0; msb_first = 1'b0; ready = 1'b1;
    start4 = 1'b0; din4 = '0; msb4 = 1'b0; ready4 = 1'b1;
    tick; tick;
    chk("rst_sout", 32'(sout), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rstn = 1'b1;
    tick;

    // LSB-first A5C3: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    scan16("lsb", 16'hA5C3, 1'b0, 16'hA5C3, -1, 0, 17, 1'b0);
    after_done("lsb");

    // MSB-first 8001: 1, fourteen 0s, 1
    scan16("msb", 16'h8001, 1'b1, 16'h8001, -1, 0, 17, 1'b0);
    after_done("msb");

    scan16("stall", 16'hA5C3, 1'b0, 16'hA5C3, 7, 3, 20, 1'b0);
    after_done("stall");

    // Mid-scan din/order change and start are ignored; bits follow 0F0F.
    scan16("ign", 16'h0F0F, 1'b0, 16'h0F0F, -1, 0, 17, 1'b1);
    din = 16'hA5C3; msb_first = 1'b0; start = 1'b1;
    tick;
    chk("ign_done_start_valid", 32'(valid), 0);
    chk("ign_done_start_busy", 32'(busy), 0);
    chk("ign_done_start_done", 32'(done), 0);
    tick;
    start = 1'b0;
    chk("b2b_period", edge_cnt - start_edge, 18);
    chk("b2b_valid", 32'(valid), 1);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_sel", 32'(sel), 0);
    chk("b2b_sout", 32'(sout), 1);

    for (int i = 0; i < 5; i++) tick;
    chk("abort_pre_sel", 32'(sel), 5);
    rstn = 1'b0;
    #1;
    chk("abort_sout", 32'(sout), 0);
    chk("abort_sel", 32'(sel), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick;
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("abort_no_done", 32'(done), 0);
      chk("abort_idle_valid", 32'(valid), 0);
    end

    // 4-bit instance, 1010 LSB-first: 0,1,0,1
    begin
      logic [3:0] seq4;
      int cyc;
      seq4 = 4'b1010;
      din4 = 4'b1010; msb4 = 1'b0; ready4 = 1'b1; start4 = 1'b1;
      tick;
      start4 = 1'b0;
      cyc = 1;
      for (int i = 0; i < 4; i++) begin
        chk("w4_valid", 32'(valid4), 1);
        chk("w4_sel", 32'(sel4), i);
        chk("w4_sout", 32'(sout4), 32'(seq4[i]));
        tick; cyc++;
      end
      chk("w4_done", 32'(done4), 1);
      chk("w4_done_cycle", cyc, 5);
      chk("w4_final_sel", 32'(sel4), 3);
      tick;
      chk("w4_done_end", 32'(done4), 0);
      chk("w4_idle_busy", 32'(busy4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
